// File: rtl/fir_sekwencer_if.sv
// Signal bundle between the FIR sequencer and its environment (sample counter,
// RAM address/enable consumers and the run-control host).
interface fir_sekwencer_if #(
  parameter int N_WSP = 6,
  parameter int N_ADR = 13
);
  logic             start;
  logic             stop;
  logic [13:0]      ile_probek;
  logic [N_WSP:0]   ile_wsp;
  logic [N_ADR-1:0] A_probki_FIR;
  logic             licznik_full;
  logic [14:0]      ile_razy;
  logic             FSM_zapisz_probki;
  logic             FSM_reset_licznik;
  logic             FSM_nowa_probka;
  logic [N_WSP-1:0] A_wsp;
  logic [N_ADR-1:0] A_probki_k;
  logic             mac_clr;
  logic             mac_en;
  logic             mac_zero;
  logic             wyn_we;
  logic             busy;
  logic             done;
  logic             cfg_err;

  // Sequencer side
  modport master (
    input  start, stop, ile_probek, ile_wsp, A_probki_FIR, licznik_full,
    output ile_razy, FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka,
           A_wsp, A_probki_k, mac_clr, mac_en, mac_zero, wyn_we, busy, done, cfg_err
  );

  // Environment side
  modport slave (
    output start, stop, ile_probek, ile_wsp, A_probki_FIR, licznik_full,
    input  ile_razy, FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka,
           A_wsp, A_probki_k, mac_clr, mac_en, mac_zero, wyn_we, busy, done, cfg_err
  );
endinterface

// File: rtl/fir_sekwencer.sv
// FIR run sequencer: per output sample walks all taps, issues zero-padded
// sample/coefficient addresses and drives the MAC, result RAM and sample counter.
module fir_sekwencer #(
  parameter int N_WSP = 6,
  parameter int N_ADR = 13
) (
  input  logic         clk_b,
  input  logic         rst,
  fir_sekwencer_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CLR, S_MAC, S_DRAIN, S_WRITE, S_NEXT, S_CHECK, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [13:0]      probek_q, probek_d;
  logic [N_WSP:0]   wsp_q, wsp_d;
  logic [14:0]      razy_q, razy_d;
  logic [N_WSP-1:0] k_q, k_d;
  logic [N_ADR-1:0] adr_q, adr_d;
  logic             mac_en_q, mac_en_d;
  logic             mac_zero_q, mac_zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             abort_q, abort_d;

  logic [14:0]      razy_new;
  logic             cfg_bad;
  logic             k_last;
  logic [N_ADR:0]   n_minus_k;
  logic             tap_valid;

  assign razy_new = 15'(bus.ile_probek) + 15'(bus.ile_wsp) - 15'd1;
  assign cfg_bad  = (bus.ile_probek == 14'd0) || (bus.ile_wsp == '0) || (razy_new > 15'd8192);
  assign k_last   = ((N_WSP+1)'(k_q) == (wsp_q - (N_WSP+1)'(1)));

  // Tap is real data only when n-k lands inside the input block; else pad with 0.
  assign n_minus_k = {1'b0, bus.A_probki_FIR} - (N_ADR+1)'(k_q);
  assign tap_valid = (bus.A_probki_FIR >= N_ADR'(k_q)) && (15'(n_minus_k) < 15'(probek_q));

  always_comb begin
    state_d    = state_q;
    probek_d   = probek_q;
    wsp_d      = wsp_q;
    razy_d     = razy_q;
    k_d        = k_q;
    adr_d      = adr_q;
    mac_en_d   = (state_q == S_MAC);
    mac_zero_d = (state_q == S_MAC) ? !tap_valid : 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    abort_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          probek_d = bus.ile_probek;
          wsp_d    = bus.ile_wsp;
          razy_d   = razy_new;
          if (cfg_bad) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD:  state_d = S_CLR;
      S_CLR: begin
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        if (k_last) state_d = S_DRAIN;
        else        k_d     = k_q + 1'b1;
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: state_d = S_NEXT;
      S_NEXT:  state_d = S_CHECK;
      S_CHECK: begin
        if (bus.licznik_full) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_CLR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort kills any in-flight accumulate and suppresses the done pulse.
    if ((state_q != S_IDLE) && bus.stop) begin
      state_d    = S_IDLE;
      abort_d    = 1'b1;
      mac_en_d   = 1'b0;
      mac_zero_d = 1'b0;
      done_d     = 1'b0;
    end

    if (state_d == S_MAC) adr_d = bus.A_probki_FIR - N_ADR'(k_d);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_b) begin
    if (rst) begin
      state_q    <= S_IDLE;
      probek_q   <= '0;
      wsp_q      <= '0;
      razy_q     <= '0;
      k_q        <= '0;
      adr_q      <= '0;
      mac_en_q   <= 1'b0;
      mac_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      probek_q   <= probek_d;
      wsp_q      <= wsp_d;
      razy_q     <= razy_d;
      k_q        <= k_d;
      adr_q      <= adr_d;
      mac_en_q   <= mac_en_d;
      mac_zero_q <= mac_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.ile_razy          = razy_q;
  assign bus.A_wsp             = k_q;
  assign bus.A_probki_k        = adr_q;
  assign bus.mac_en            = mac_en_q;
  assign bus.mac_zero          = mac_zero_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.cfg_err           = err_q;
  assign bus.mac_clr           = (state_q == S_CLR);
  assign bus.FSM_zapisz_probki = (state_q == S_LOAD);
  assign bus.FSM_reset_licznik = (state_q == S_LOAD) || abort_q;
  assign bus.FSM_nowa_probka   = (state_q == S_NEXT);
  assign bus.wyn_we            = (state_q == S_WRITE);
endmodule

// File: tb/tb_fir_sekwencer.sv
// Scoreboard bench for fir_sekwencer: a convolution-index model predicts every
// accumulate, write and done event; a negedge monitor consumes them.
module tb_fir_sekwencer;
  logic clk_b;
  logic rst;

  fir_sekwencer_if #(.N_WSP(6), .N_ADR(13)) bus();

  fir_sekwencer #(.N_WSP(6), .N_ADR(13)) dut (
    .clk_b (clk_b),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk_b = 1'b0;
  always #5 clk_b = ~clk_b;

  // Behavioural sample counter sitting between the sequencer strobes and n.
  logic [13:0] cnt;
  logic [14:0] lim;
  always @(posedge clk_b) begin
    if (rst) begin
      cnt <= '0;
      lim <= '0;
    end else begin
      if (bus.FSM_zapisz_probki) lim <= bus.ile_razy;
      if (bus.FSM_reset_licznik)  cnt <= '0;
      else if (bus.FSM_nowa_probka) cnt <= cnt + 14'd1;
    end
  end
  assign bus.A_probki_FIR = cnt[12:0];
  assign bus.licznik_full = (15'(cnt) == lim);

  typedef struct packed {
    logic        zero;
    logic [5:0]  k;
    logic [12:0] addr;
  } mac_t;
  typedef struct packed {
    logic err;
    logic busy;
  } done_t;

  mac_t        exp_mac[$];
  logic [12:0] exp_wr[$];
  done_t       exp_done[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  logic [5:0]  prev_k;
  logic [12:0] prev_addr;
  always @(negedge clk_b) begin
    if (!rst) begin
      if (bus.mac_en) begin
        if (exp_mac.size() == 0) chk("mac_unexpected", 1, 0);
        else begin
          mac_t e;
          e = exp_mac.pop_front();
          chk("mac_tap", {12'd0, bus.mac_zero, prev_k, prev_addr}, {12'd0, e});
        end
      end
      if (bus.mac_clr) chk("clr_vs_en", {31'd0, bus.mac_en}, 32'd0);
      if (bus.wyn_we) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr_index", {19'd0, bus.A_probki_FIR}, {19'd0, exp_wr.pop_front()});
      end
      if (bus.done) begin
        if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
        else chk("done_flags", {30'd0, bus.cfg_err, bus.busy}, {30'd0, exp_done.pop_front()});
      end
    end
    prev_k    = bus.A_wsp;
    prev_addr = bus.A_probki_k;
  end

  // Reference: output y[n] = sum_k h[k]*x[n-k], x outside 0..P-1 reads as 0.
  task automatic push_model(input int p, input int w, input int ab_n, input int ab_k);
    int razy;
    mac_t e;
    razy = p + w - 1;
    for (int n = 0; n < razy; n++) begin
      for (int k = 0; k < w; k++) begin
        if (ab_n < 0 || n < ab_n || (n == ab_n && k < ab_k)) begin
          e.zero = !((n >= k) && (n - k < p));
          e.k    = 6'(k);
          e.addr = 13'((n - k) & 32'h1fff);
          exp_mac.push_back(e);
        end
      end
      if (ab_n < 0 || n < ab_n) exp_wr.push_back(13'(n));
    end
    if (ab_n < 0) exp_done.push_back('{err: 1'b0, busy: 1'b1});
  endtask

  task automatic run(input int p, input int w, input int ab_n, input int ab_k);
    int  razy, exp_cyc, stop_cyc, limit;
    bit  err, seen;
    razy = (p + w - 1) & 32'h7fff;
    err  = (p == 0) || (w == 0) || (razy > 8192);
    if (err) exp_done.push_back('{err: 1'b1, busy: 1'b0});
    else     push_model(p, w, ab_n, ab_k);
    exp_cyc  = err ? 1 : 2 + razy * (w + 5);
    stop_cyc = (ab_n >= 0) ? 2 + ab_n * (w + 5) + 1 + ab_k : -1;
    limit    = (ab_n >= 0) ? stop_cyc + 30 : exp_cyc + 3;
    seen     = 1'b0;

    @(negedge clk_b);
    bus.ile_probek = 14'(p);
    bus.ile_wsp    = 7'(w);
    bus.start      = 1'b1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk_b);
      if (i == 1) begin
        chk("ile_razy", {17'd0, bus.ile_razy}, razy);
        if (err) chk("err_flags", {30'd0, bus.cfg_err, bus.busy}, 32'd2);
        else     chk("load_strobes", {29'd0, bus.FSM_zapisz_probki, bus.FSM_reset_licznik, bus.cfg_err}, 32'd6);
      end
      if (i == stop_cyc + 1)
        chk("abort_state", {30'd0, bus.busy, bus.FSM_reset_licznik}, 32'd1);
      if (bus.done && !seen) begin
        seen = 1'b1;
        if (ab_n < 0) chk("done_cycle", i, exp_cyc);
      end
      bus.start = 1'b0;
      bus.stop  = (i == stop_cyc);
    end
    bus.stop = 1'b0;
    if (ab_n >= 0) chk("abort_no_done", {31'd0, seen}, 32'd0);
    else if (!seen) chk("done_timeout", 0, 1);
    chk("mac_left", exp_mac.size(), 0);
    chk("wr_left", exp_wr.size(), 0);
    chk("done_left", exp_done.size(), 0);
    $display("run p=%0d w=%0d abort=%0d/%0d err=%0b busy=%0b total=%0d bad=%0d",
             p, w, ab_n, ab_k, err, bus.busy, total, bad);
  endtask

  initial begin
    int p, w, an, ak;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.stop = 1'b0;
    bus.ile_probek = 14'd4;
    bus.ile_wsp = 7'd3;
    repeat (3) @(negedge clk_b);
    chk("rst_outs_a", {14'd0, bus.ile_razy, bus.FSM_zapisz_probki, bus.FSM_reset_licznik,
                       bus.FSM_nowa_probka}, 32'd0);
    chk("rst_outs_b", {6'd0, bus.A_wsp, bus.A_probki_k, bus.mac_clr, bus.mac_en, bus.mac_zero,
                       bus.wyn_we, bus.busy, bus.done, bus.cfg_err}, 32'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk_b);
    chk("start_in_rst", {30'd0, bus.busy, bus.done}, 32'd0);
    $display("reset checked total=%0d bad=%0d", total, bad);

    run(4, 0, -1, 0);
    run(8192, 2, -1, 0);
    run(4, 3, -1, 0);
    run(4, 0, -1, 0);
    run(4, 3, 2, 1);
    run(4, 3, -1, 0);
    run(1, 1, -1, 0);
    for (int r = 0; r < 6; r++) begin
      p = $urandom_range(1, 12);
      w = $urandom_range(1, 8);
      run(p, w, -1, 0);
    end
    for (int r = 0; r < 2; r++) begin
      p = $urandom_range(8180, 8192);
      w = $urandom_range(8194 - p, 64);
      run(p, w, -1, 0);
    end
    for (int r = 0; r < 2; r++) begin
      p  = $urandom_range(1, 8);
      w  = $urandom_range(2, 6);
      an = $urandom_range(0, p + w - 2);
      ak = $urandom_range(1, w - 1);
      run(p, w, an, ak);
      run(p, w, -1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_sekwencer.md
Name: fir_sekwencer

Overview:
- Top-level FSM sequencing one FIR convolution run over sample RAM, coefficient RAM and result RAM.
- Drives the sample address counter through its FSM_zapisz_probki, FSM_reset_licznik and FSM_nowa_probka strobes, and supplies its ile_razy limit.
- Per output sample it walks all coefficients, issues sample and coefficient addresses with zero-padding, and controls the MAC accumulator and the result-RAM write strobe.

Parameters:
- N_WSP, 6, coefficient address width; at most 2^N_WSP coefficients.
- N_ADR, 13, sample address width; must match the counter.

Ports:
- clk_b  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin a run; ignored unless IDLE.
- stop  in  1  synchronous abort; any non-IDLE state returns to IDLE.
- ile_probek  in  14  number of input samples, 1..8192.
- ile_wsp  in  N_WSP+1  number of coefficients, 1..2^N_WSP.
- A_probki_FIR  in  N_ADR  current output index n from the counter.
- licznik_full  in  1  counter reached its limit.
- ile_razy  out  15  latched ile_probek+ile_wsp-1, fed to the counter.
- FSM_zapisz_probki  out  1  counter limit load strobe.
- FSM_reset_licznik  out  1  counter clear strobe.
- FSM_nowa_probka  out  1  counter increment strobe.
- A_wsp  out  N_WSP  coefficient RAM address k.
- A_probki_k  out  N_ADR  sample RAM address n-k, modulo 2^N_ADR.
- mac_clr  out  1  clear accumulator.
- mac_en  out  1  accumulate, aligned to RAM data (1 cycle after address).
- mac_zero  out  1  with mac_en: add 0 (padding); valid only when mac_en=1.
- wyn_we  out  1  result RAM write strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle end-of-run pulse.
- cfg_err  out  1  sticky config error flag; cleared by the next accepted start.

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0, including ile_razy and cfg_err.
  - Internal k=0, latched config=0.
  - Reset wins over start and stop in the same cycle.
- Registered outputs: all outputs are registered except mac_clr, FSM_* and wyn_we, which are Moore decodes of the state register.
- ile_razy: 15-bit add, no truncation; stays valid until the next start.
- IDLE, on start:
  - Latch ile_probek and ile_wsp; compute ile_razy.
  - If ile_probek=0, ile_wsp=0 or ile_razy>8192: cfg_err<=1, done pulses next cycle, stay IDLE.
  - Otherwise: cfg_err<=0, go to LOAD.
- LOAD (1 cycle): FSM_zapisz_probki=1 and FSM_reset_licznik=1 -> CLR.
- CLR (1 cycle): mac_clr=1, k<=0 -> MAC.
- MAC (ile_wsp cycles), each cycle:
  - A_wsp=k; A_probki_k=n-k.
  - valid = (n>=k) && (n-k < ile_probek).
  - Registered one cycle later: mac_en=1, mac_zero=!valid.
  - k increments each cycle; at k=ile_wsp-1 -> DRAIN.
- DRAIN (1 cycle): last mac_en occurs here -> WRITE.
- WRITE (1 cycle): wyn_we=1; n is stable -> NEXT.
- NEXT (1 cycle): FSM_nowa_probka=1 -> CHECK.
- CHECK (1 cycle): licznik_full=1 -> DONE; else -> CLR.
- DONE (1 cycle): done=1 -> IDLE.
- Cycles per output sample = ile_wsp+5; a run takes 1+ile_razy*(ile_wsp+5)+1 cycles.
- mac_en is never high in CLR or in the cycle after it, so no accumulate coincides with a clear.
- stop in a non-IDLE state:
  - Next state is IDLE with FSM_reset_licznik=1 for that one cycle.
  - mac_en and wyn_we are forced to 0 from that cycle on.
  - No done pulse.
- stop in IDLE: no effect.
- start when not IDLE: ignored. start and stop together in IDLE: start is accepted.
- Address wrap: for n<k, A_probki_k wraps (e.g. n=0, k=1 gives 8191), but mac_zero=1 masks it.

Test Plan:
- Reset then idle: hold rst 3 cycles -> all outputs 0, busy=0; start while rst=1 -> ignored.
- Normal run, ile_probek=4, ile_wsp=3:
  - ile_razy=6.
  - LOAD strobes both counter inputs one cycle after start.
  - 6 wyn_we pulses at n=0..5, 8 cycles apart.
  - done in cycle 50 after start.
- Zero-padding, same run:
  - n=0: mac_zero pattern k0..2 = 0,1,1.
  - n=5: pattern = 1,1,0.
  - n=2: pattern = 0,0,0.
- Config errors: ile_wsp=0 -> cfg_err=1, done pulses, busy stays 0. ile_probek=8192 with ile_wsp=2 -> ile_razy=8193 -> cfg_err=1.
- Abort: stop during MAC of n=2 -> next cycle IDLE, FSM_reset_licznik=1, no further wyn_we, no done. A following start runs fully and clears cfg_err.
- Single tap, ile_probek=1, ile_wsp=1: ile_razy=1, one wyn_we, mac_zero=0, done in cycle 8.
